carry_select_subtractor_pipe: RTL and testbench
===============================================

Name: carry_select_subtractor_pipe

Overview:
- Two-stage pipelined 32-bit subtractor: D = A - B, computed as A + ~B + 1 with 4-bit carry-select blocks.
- It is the inverse-operation companion to the team's combinational carry-select adder, for datapaths that need subtraction, compare and borrow at full clock rate.
- Valid/ready handshake on both sides; throughput of one operation per cycle.
- Sits between operand registers and ALU/compare consumers.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 2*NIBBLE.
- NIBBLE, 4, carry-select block width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  A/B operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A - B, modulo 2^WIDTH.
- borrow  output  1  1 iff unsigned A < B (inverted carry-out).
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
- zero  output  1  1 iff diff == 0.

Behaviour:
- Accept and deliver rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1, combinational from a and b, registered into s1 on accept:
  - Low half: nibble 0 uses carry-in 1. Each later low nibble is selected by the previous nibble's carry, as in a carry-select chain. This produces d_lo[WIDTH/2-1:0] and carry c_mid.
  - High half: computes two complete candidates, hi0 (carry-in 0) and hi1 (carry-in 1), each with its own carry-out (co0, co1) and internal carry-select chain.
  - Registered: d_lo, hi0, hi1, co0, co1, c_mid, a[MSB], b[MSB], s1_valid.
- Stage 2, registered into the output registers:
  - d_hi = c_mid ? hi1 : hi0.
  - cout = c_mid ? co1 : co0.
  - diff = {d_hi, d_lo}; borrow = ~cout; ovf and zero derived from the stage-2 values.
  - All four flags are registered together with diff and out_valid.
- Latency: result valid exactly 2 cycles after the accepting edge, with no stall.
- Pipeline flow control, no combinational path from out_ready to in_ready other than through the stage-advance terms:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
- Stall: with out_valid=1 and out_ready=0, both stages hold their data and flags unchanged; in_ready=0 once s1 is occupied. No data is lost or duplicated.
- Bubbles: out_valid falls after a transfer if s1 is empty. Back-to-back accepts produce back-to-back outputs.
- Simultaneous accept and output transfer in the same cycle is legal. Full throughput is maintained.
- Reset:
  - While rst=1: s1_valid=0, out_valid=0, diff=0, borrow=0, ovf=0, zero=0.
  - in_ready=1 in the first cycle after rst deasserts. During rst, in_ready=0.
  - Reset mid-operation discards in-flight results with no output.
- Data outputs are don't-care-stable: they change only on a stage-2 load.
- Wrap-around: 0 - 1 gives diff=all-ones, borrow=1. No saturation.

Decomposition:
- Package sub_pkg:
  - WIDTH_DEFAULT=32, NIBBLE_DEFAULT=4.
  - typedef s1_t, a struct of the stage-1 registered fields.
  - Function ovf_f(a_msb, b_msb, d_msb).
- Sub-module nibble_sub_pair: for one NIBBLE slice of A and ~B, outputs sum/carry for carry-in 0 and carry-in 1. It is instantiated WIDTH/NIBBLE times; nibble 0 uses only its carry-in-1 outputs.

Test Plan:
- Reset then single op: a=0x0000_0005, b=0x0000_0003, in_valid one cycle -> 2 cycles later out_valid=1, diff=0x0000_0002, borrow=0, ovf=0, zero=0.
- Borrow and wrap: a=0, b=1 -> diff=0xFFFF_FFFF, borrow=1, ovf=0. Then a=b=0x1234_5678 -> diff=0, zero=1, borrow=0.
- Mid-boundary carry select:
  - a=0x0001_0000, b=0x0000_0001 -> diff=0x0000_FFFF, which exercises the c_mid=0 path.
  - a=0x0001_FFFF, b=0x0000_FFFF -> diff=0x0001_0000, which exercises c_mid=1.
- Signed overflow:
  - a=0x8000_0000, b=1 -> diff=0x7FFF_FFFF, ovf=1, borrow=0.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, ovf=1, borrow=1.
- Backpressure: stream 8 random ops with out_ready toggling on a pseudo-random pattern -> outputs match a scoreboard in order; no drops or duplicates; in_ready=0 whenever both stages are full and out_ready=0; 1 op/cycle when out_ready=1 throughout.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle before they emerge -> no out_valid for them; outputs all zero; the next op after reset completes with correct latency 2.

Source files
------------

// File: rtl/carry_select_subtractor_pipe_pkg.sv
// rtl/carry_select_subtractor_pipe_pkg.sv - shared types, defaults and helpers for the pipelined subtractor
// Contents: WIDTH_DEFAULT/NIBBLE_DEFAULT, s1_t stage-1 register layout, ovf_f signed-overflow helper.
package sub_pkg;

    localparam int WIDTH_DEFAULT  = 32;
    localparam int NIBBLE_DEFAULT = 4;
    localparam int HALF_DEFAULT   = WIDTH_DEFAULT / 2;

    // Stage-1 register contents; field widths follow the default operand width.
    typedef struct packed {
        logic [HALF_DEFAULT-1:0] d_lo;
        logic [HALF_DEFAULT-1:0] hi0;
        logic [HALF_DEFAULT-1:0] hi1;
        logic                    co0;
        logic                    co1;
        logic                    c_mid;
        logic                    a_msb;
        logic                    b_msb;
    } s1_t;

    // Subtraction overflows only when the operand signs differ and the
    // result sign disagrees with the minuend.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/nibble_sub_pair.sv
// rtl/nibble_sub_pair.sv - one carry-select slice producing A + ~B for both carry-in values
// Ports: a_nib/nb_nib slice of A and of ~B; sum0/cout0 result for carry-in 0; sum1/cout1 for carry-in 1.
module nibble_sub_pair
    import sub_pkg::*;
#(
    parameter int NIBBLE = NIBBLE_DEFAULT
) (
    input  logic [NIBBLE-1:0] a_nib,
    input  logic [NIBBLE-1:0] nb_nib,
    output logic [NIBBLE-1:0] sum0,
    output logic              cout0,
    output logic [NIBBLE-1:0] sum1,
    output logic              cout1
);

    assign {cout0, sum0} = {1'b0, a_nib} + {1'b0, nb_nib};
    assign {cout1, sum1} = {1'b0, a_nib} + {1'b0, nb_nib} + (NIBBLE+1)'(1);

endmodule

// File: rtl/carry_select_subtractor_pipe.sv
// rtl/carry_select_subtractor_pipe.sv - two-stage pipelined carry-select subtractor (diff = a - b)
// Ports: clk, rst (sync, active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/diff/borrow/ovf/zero result handshake.
module carry_select_subtractor_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int NIBBLE = NIBBLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int HALF = WIDTH / 2;
    localparam int NN   = WIDTH / NIBBLE;
    localparam int HN   = NN / 2;

    logic [WIDTH-1:0]  b_inv;
    logic [NIBBLE-1:0] ns0 [NN];
    logic [NIBBLE-1:0] ns1 [NN];
    logic              nc0 [NN];
    logic              nc1 [NN];

    assign b_inv = ~b;

    for (genvar g = 0; g < NN; g++) begin : g_nib
        nibble_sub_pair #(.NIBBLE(NIBBLE)) u_pair (
            .a_nib  (a[g*NIBBLE +: NIBBLE]),
            .nb_nib (b_inv[g*NIBBLE +: NIBBLE]),
            .sum0   (ns0[g]),
            .cout0  (nc0[g]),
            .sum1   (ns1[g]),
            .cout1  (nc1[g])
        );
    end

    // Stage 1: low half ripples its select chain from the +1 of two's
    // complement; the high half resolves both carry-in hypotheses so that
    // stage 2 only needs a single mux on c_mid.
    s1_t s1_new;
    always_comb begin : p_stage1
        logic c_lo;
        logic c_h0;
        logic c_h1;
        s1_new = '0;
        c_lo   = 1'b1;
        c_h0   = 1'b0;
        c_h1   = 1'b1;
        for (int i = 0; i < HN; i++) begin
            s1_new.d_lo[i*NIBBLE +: NIBBLE] = c_lo ? ns1[i] : ns0[i];
            c_lo = c_lo ? nc1[i] : nc0[i];
            s1_new.hi0[i*NIBBLE +: NIBBLE]  = c_h0 ? ns1[HN+i] : ns0[HN+i];
            c_h0 = c_h0 ? nc1[HN+i] : nc0[HN+i];
            s1_new.hi1[i*NIBBLE +: NIBBLE]  = c_h1 ? ns1[HN+i] : ns0[HN+i];
            c_h1 = c_h1 ? nc1[HN+i] : nc0[HN+i];
        end
        s1_new.c_mid = c_lo;
        s1_new.co0   = c_h0;
        s1_new.co1   = c_h1;
        s1_new.a_msb = a[WIDTH-1];
        s1_new.b_msb = b[WIDTH-1];
    end

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s2_adv, s1_adv, accept, s2_load;
    logic [HALF-1:0]  d_hi;
    logic             cout;
    logic [WIDTH-1:0] diff_new;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !rst;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s2_adv && s1_valid_q;

    assign d_hi     = s1_q.c_mid ? s1_q.hi1 : s1_q.hi0;
    assign cout     = s1_q.c_mid ? s1_q.co1 : s1_q.co0;
    assign diff_new = {d_hi, s1_q.d_lo};

    // Data registers move only on a load so outputs stay stable across
    // stalls and bubbles.
    always_comb begin
        s1_valid_d  = s1_adv ? accept : s1_valid_q;
        s1_d        = accept ? s1_new : s1_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        diff_d      = s2_load ? diff_new : diff_q;
        borrow_d    = s2_load ? ~cout : borrow_q;
        ovf_d       = s2_load ? ovf_f(s1_q.a_msb, s1_q.b_msb, diff_new[WIDTH-1]) : ovf_q;
        zero_d      = s2_load ? (diff_new == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// tb/tb_carry_select_subtractor_pipe.sv - self-checking bench for carry_select_subtractor_pipe
module tb_carry_select_subtractor_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, diff;
    logic         borrow, ovf, zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        logic         z;
    } vec_t;

    exp_t sb[$];

    carry_select_subtractor_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.br = (x < y);
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        e.z  = (e.d == '0);
        return e;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b1; a = W'(c + 7); b = 1; out_ready = 1'b1;
            #1;
            n_checks++;
            if ({out_valid, diff, borrow, ovf, zero} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", {out_valid, diff, borrow, ovf, zero});
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_ready: got %b expected 0", in_ready);
            end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_no_output: got %b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_directed();
        vec_t tbl [8];
        vec_t t;
        int   lat;
        tbl = '{
            '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
            '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
            '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0},
            '{32'h0001_FFFF, 32'h0000_FFFF, 32'h0001_0000, 1'b0, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
            '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0},
            '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            t = tbl[i];
            @(negedge clk);
            in_valid = 1'b1; a = t.va; b = t.vb; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_accept[%0d]: got in_ready=%b expected 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat = 1;
            while (!out_valid && lat < 6) begin
                @(negedge clk); #1;
                lat++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || lat != 2) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (out_valid=%b) expected 2", i, lat, out_valid);
            end
            n_checks++;
            if ({diff, borrow, ovf, zero} !== {t.d, t.br, t.ov, t.z}) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got diff=%h b=%b o=%b z=%b expected diff=%h b=%b o=%b z=%b",
                         i, diff, borrow, ovf, zero, t.d, t.br, t.ov, t.z);
            end
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || diff !== t.d) begin
                n_fail++;
                $display("FAIL directed_bubble_hold[%0d]: got out_valid=%b diff=%h expected 0 %h", i, out_valid, diff, t.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0, recv = 0, first = -1, last = -1, stalls = 0;
        exp_t e;
        sb.delete();
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 8) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) stalls++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_output: got diff=%h expected none", diff);
                end else begin
                    e = sb.pop_front();
                    if ({diff, borrow, ovf, zero} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h expected %h", {diff, borrow, ovf, zero}, e);
                    end
                end
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 8", recv);
        end
        n_checks++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %0d stalled cycles expected 0", stalls);
        end
        n_checks++;
        if (last - first != 7) begin
            n_fail++;
            $display("FAIL b2b_throughput: got span %0d expected 7", last - first);
        end
    endtask

    task automatic test_backpressure();
        int           sent = 0, recv = 0;
        logic         have = 1'b0;
        logic [W-1:0] na = '0, nb = '0;
        logic         prev_stall = 1'b0;
        logic [W:0]   prev_out = '0;
        logic         exp_rdy;
        exp_t         e;
        sb.delete();
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'(($urandom_range(0, 2) == 0) ? 0 : (cyc % 3 != 1));
            if (sent < 8) begin
                if (!have) begin
                    na = $urandom; nb = $urandom; have = 1'b1;
                end
                in_valid = 1'b1; a = na; b = nb;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = !(sb.size() == 2 && !out_ready);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d]: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            if (prev_stall) begin
                n_checks++;
                if ({out_valid, diff} !== prev_out) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold[%0d]: got %h expected %h", cyc, {out_valid, diff}, prev_out);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, diff};
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_unexpected_output: got diff=%h expected none", diff);
                end else begin
                    e = sb.pop_front();
                    if ({diff, borrow, ovf, zero} !== e) begin
                        n_fail++;
                        $display("FAIL bp_result: got %h expected %h", {diff, borrow, ovf, zero}, e);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b));
                sent++;
                have = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv != 8 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs (%0d pending) expected 8 (0)", recv, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd4;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_accept0: got %b expected 1", in_ready);
        end
        @(negedge clk);
        a = 32'd20; b = 32'd5;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_accept1: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, diff, borrow, ovf, zero} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_cleared: got %h in_ready=%b expected 0 in_ready=1",
                     {out_valid, diff, borrow, ovf, zero}, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_discarded: got out_valid=%b expected 0", out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b1; a = 32'h0000_0100; b = 32'h0000_0001;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_lat1: got out_valid=%b expected 0", out_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({out_valid, diff, borrow, ovf, zero} !== {1'b1, 32'h0000_00FF, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_after_result: got %h expected %h",
                     {out_valid, diff, borrow, ovf, zero}, {1'b1, 32'h0000_00FF, 3'b000});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
